// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate controller.
// State encoding is fixed at 3 bits; StatsWidth sizes the optional gated-cycle counter.
package clk_gate_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GATED = 3'd3,
        ST_WAKE  = 3'd4
    } gate_state_e;

    localparam int unsigned StatsWidth = 32;

endpackage

// File: rtl/clk_gate_idle_cnt.sv
// Idle-cycle counter: clr wins over inc, saturates at IdleCycles-1 and never wraps.
// done is high while the count sits at IdleCycles-1.
module clk_gate_idle_cnt #(
    parameter int unsigned IdleCycles = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);

    localparam int unsigned CntW = $clog2(IdleCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(IdleCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CntMax);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller driving the enable of an external gating cell.
// Define CLK_GATE_CTRL_STATS_EN to add the saturating gated_cycles_o counter.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned IdleCycles = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] busy_i,
    input  logic              wake_i,
    input  logic              gate_ack_i,
    output logic              gate_req_o,
    output logic              clk_en_o,
`ifdef CLK_GATE_CTRL_STATS_EN
    output logic [StatsWidth-1:0] gated_cycles_o,
`endif
    output logic              active_o
);

    gate_state_e state_q, state_d;
    logic        abort_q, abort_d;
    logic        gate_req_q, gate_req_d;
    logic        clk_en_q, clk_en_d;
    logic        active_q, active_d;
    logic        idle;
    logic        cnt_clr, cnt_inc, cnt_done;

    assign idle = (busy_i == '0) && !wake_i;

    // The counter only advances on idle samples while waiting in IDLE.
    assign cnt_inc = (state_q == ST_IDLE) && idle;
    assign cnt_clr = !cnt_inc;

    clk_gate_idle_cnt #(
        .IdleCycles(IdleCycles)
    ) u_idle_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .done_o (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        unique case (state_q)
            ST_RUN: begin
                abort_d = 1'b0;
                if (idle) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!idle)         state_d = ST_RUN;
                else if (cnt_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Abort is sticky: any activity seen while draining cancels the gate.
                if (gate_ack_i) begin
                    abort_d = 1'b0;
                    state_d = (abort_q || !idle) ? ST_RUN : ST_GATED;
                end else if (!idle) begin
                    abort_d = 1'b1;
                end
            end
            ST_GATED: begin
                if (!idle) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                abort_d = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change in step with it.
    always_comb begin
        gate_req_d = (state_d == ST_DRAIN);
        clk_en_d   = (state_d != ST_GATED);
        active_d   = (state_d == ST_RUN) || (state_d == ST_IDLE) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            abort_q    <= 1'b0;
            gate_req_q <= 1'b0;
            clk_en_q   <= 1'b1;
            active_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            abort_q    <= abort_d;
            gate_req_q <= gate_req_d;
            clk_en_q   <= clk_en_d;
            active_q   <= active_d;
        end
    end

    assign gate_req_o = gate_req_q;
    assign clk_en_o   = clk_en_q;
    assign active_o   = active_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [StatsWidth-1:0] gated_cycles_q, gated_cycles_d;

    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if ((state_q == ST_GATED) && (gated_cycles_q != {StatsWidth{1'b1}})) begin
            gated_cycles_d = gated_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gated_cycles_q <= '0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`else
    // Statistics disabled: no counter and no gated_cycles_o port.
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with IdleCycles=4, NumReq=4.
// Each cycle: advance one clock edge, wait 1 time unit, drive inputs, check outputs.
module tb_clk_gate_ctrl;

  localparam int NumReq     = 4;
  localparam int IdleCycles = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NumReq-1:0] busy;
  logic              wake;
  logic              gate_ack;
  logic              gate_req;
  logic              clk_en;
  logic              active;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [31:0]       gated_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NumReq     (NumReq),
    .IdleCycles (IdleCycles)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .busy_i         (busy),
    .wake_i         (wake),
    .gate_ack_i     (gate_ack),
    .gate_req_o     (gate_req),
    .clk_en_o       (clk_en),
`ifdef CLK_GATE_CTRL_STATS_EN
    .gated_cycles_o (gated_cycles),
`endif
    .active_o       (active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic req, input logic en, input logic act);
    check({tag, ".gate_req"}, {31'd0, gate_req}, {31'd0, req});
    check({tag, ".clk_en"},   {31'd0, clk_en},   {31'd0, en});
    check({tag, ".active"},   {31'd0, active},   {31'd0, act});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From RUN/IDLE with no activity: wait (bounded) for DRAIN, ack it, land in first GATED cycle.
  task automatic run_to_gated(input string tag);
    int waited;
    busy = '0;
    wake = 1'b0;
    gate_ack = 1'b0;
    waited = 0;
    while (!gate_req && waited < 20) begin
      step();
      waited++;
    end
    check({tag, ".drain_reached"}, {31'd0, gate_req}, 32'd1);
    gate_ack = 1'b1;
    step();
    gate_ack = 1'b0;
    check_out({tag, ".gated"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    busy = 4'b0001;
    wake = 1'b0;
    gate_ack = 1'b0;
    step();
    check_out("reset", 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    step();
    step();
    check_out("run_busy", 1'b0, 1'b1, 1'b1);

    // Idle from cycle A: DRAIN at A+5, ack at A+7, GATED at A+8; ack in IDLE ignored.
    busy = '0;
    check_out("t1_a", 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      gate_ack = (i == 2);
      check_out($sformatf("t1_idle%0d", i), 1'b0, 1'b1, 1'b1);
    end
    step();
    gate_ack = 1'b0;
    check_out("t1_drain5", 1'b1, 1'b1, 1'b1);
    step();
    check_out("t1_drain6", 1'b1, 1'b1, 1'b1);
    step();
    gate_ack = 1'b1;
    check_out("t1_drain7", 1'b1, 1'b1, 1'b1);
    step();
    gate_ack = 1'b0;
    check_out("t1_gated8", 1'b0, 1'b0, 1'b0);

    // Ack while gated is ignored.
    gate_ack = 1'b1;
    step();
    gate_ack = 1'b0;
    check_out("gated_ack_ignored", 1'b0, 1'b0, 1'b0);
    step();
    check_out("gated_hold", 1'b0, 1'b0, 1'b0);

    // Wake from GATED via busy: WAKE then RUN.
    busy = 4'b0100;
    step();
    check_out("t4_wake", 1'b0, 1'b1, 1'b0);
    step();
    check_out("t4_run", 1'b0, 1'b1, 1'b1);

    // Busy pulse in third IDLE cycle restarts the full 4+1 delay.
    busy = '0;
    step();
    step();
    step();
    check_out("t2_idle3", 1'b0, 1'b1, 1'b1);
    busy = 4'b0001;
    step();
    busy = '0;
    check_out("t2_run", 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_out($sformatf("t2_wait%0d", i), 1'b0, 1'b1, 1'b1);
    end
    step();
    check_out("t2_drain", 1'b1, 1'b1, 1'b1);

    // Wake pulse during DRAIN: request held until ack, then back to RUN.
    wake = 1'b1;
    step();
    wake = 1'b0;
    check_out("t3_drain1", 1'b1, 1'b1, 1'b1);
    step();
    check_out("t3_drain2", 1'b1, 1'b1, 1'b1);
    step();
    gate_ack = 1'b1;
    check_out("t3_drain3", 1'b1, 1'b1, 1'b1);
    step();
    gate_ack = 1'b0;
    busy = 4'b1000;
    check_out("t3_run", 1'b0, 1'b1, 1'b1);
    step();
    check_out("t3_run_hold", 1'b0, 1'b1, 1'b1);

    // Activity in the ack cycle itself also cancels gating.
    busy = '0;
    begin
      int waited = 0;
      while (!gate_req && waited < 20) begin
        step();
        waited++;
      end
    end
    check("ackbusy.drain_reached", {31'd0, gate_req}, 32'd1);
    gate_ack = 1'b1;
    busy = 4'b0010;
    step();
    gate_ack = 1'b0;
    check_out("ackbusy_run", 1'b0, 1'b1, 1'b1);
    step();
    check_out("ackbusy_hold", 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while GATED.
    run_to_gated("t5");
    step();
    check_out("t5_gated_hold", 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("t5_async_rst", 1'b0, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    busy = 4'b0001;
    step();
    check_out("t5_after_rst", 1'b0, 1'b1, 1'b1);

`ifdef CLK_GATE_CTRL_STATS_EN
    check("stats_reset", gated_cycles, 32'd0);
    run_to_gated("s1");
    for (int i = 1; i <= 99; i++) step();
    busy = 4'b0100;
    step();
    check("stats_100", gated_cycles, 32'd100);
    step();
    run_to_gated("s2");
    dut.gated_cycles_q = 32'hFFFF_FFFE;
    for (int i = 1; i <= 4; i++) step();
    busy = 4'b0100;
    step();
    check("stats_sat", gated_cycles, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
